uart_prog_loader: RTL and testbench

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

---
 rtl/uart_prog_loader.sv | 218 +++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// UART program loader: receives a little-endian word count followed by that many
// little-endian words over UART and writes them into the instruction ROM while holding the core.
module uart_prog_loader #(
    parameter int unsigned DW       = 32,
    parameter int unsigned ADDR_BIT = 32,
    parameter int unsigned DEPTH    = 4096,
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                uart_rx_i,
    input  logic                load_req_i,
    output logic                wmem_en_o,
    output logic [ADDR_BIT-1:0] wmem_addr_o,
    output logic [DW-1:0]       wmem_data_o,
    output logic                core_hold_o,
    output logic                load_done_o,
    output logic                err_o,
    output logic [ADDR_BIT-1:0] word_cnt_o
);

    localparam int unsigned BPW  = DW / 8;
    localparam int unsigned BCW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned CNTW = $clog2(BAUD_DIV);
    localparam int unsigned HALF = BAUD_DIV / 2;
    localparam int unsigned CW   = ((DW > ADDR_BIT) ? DW : ADDR_BIT) + 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR} ld_state_e;

    logic                rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e           rx_state_q, rx_state_d;
    logic [CNTW-1:0]     baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                byte_valid_q, byte_valid_d;
    logic                frame_err_q, frame_err_d;

    ld_state_e           state_q, state_d;
    logic [BCW-1:0]      byte_cnt_q, byte_cnt_d;
    logic [DW-1:0]       asm_q, asm_d;
    logic [DW-1:0]       n_q, n_d;
    logic [ADDR_BIT-1:0] word_cnt_q, word_cnt_d;
    logic                wmem_en_q, wmem_en_d;
    logic [ADDR_BIT-1:0] wmem_addr_q, wmem_addr_d;
    logic [DW-1:0]       wmem_data_q, wmem_data_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    // UART receiver: falling edge starts a frame, mid-bit sampling thereafter
    always_comb begin
        rx_state_d   = rx_state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    baud_d     = '0;
                end
            end
            RX_START: begin
                if (baud_q == CNTW'(HALF - 1)) begin
                    baud_d = '0;
                    bit_d  = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    baud_d = baud_q + CNTW'(1);
                end
            end
            RX_DATA: begin
                if (baud_q == CNTW'(BAUD_DIV - 1)) begin
                    baud_d  = '0;
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    baud_d = baud_q + CNTW'(1);
                end
            end
            RX_STOP: begin
                if (baud_q == CNTW'(BAUD_DIV - 1)) begin
                    baud_d       = '0;
                    rx_state_d   = RX_IDLE;
                    byte_valid_d = rx_s2_q;
                    frame_err_d  = !rx_s2_q;
                end else begin
                    baud_d = baud_q + CNTW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Loader FSM: header word count, then word assembly and ROM writes
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        n_d         = n_q;
        word_cnt_d  = word_cnt_q;
        wmem_en_d   = 1'b0;
        wmem_addr_d = wmem_addr_q;
        wmem_data_d = wmem_data_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (load_req_i) begin
                    state_d    = S_HDR;
                    word_cnt_d = '0;
                    err_d      = 1'b0;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                end
            end
            S_HDR: begin
                if (frame_err_q) begin
                    state_d = S_ERR;
                end else if (byte_valid_q) begin
                    asm_d = (asm_q >> 8) | (DW'(shift_q) << (DW - 8));
                    if (byte_cnt_q == BCW'(BPW - 1)) begin
                        byte_cnt_d = '0;
                        n_d        = asm_d;
                        if (CW'(asm_d) > CW'(DEPTH))  state_d = S_ERR;
                        else if (asm_d == '0)         state_d = S_DONE;
                        else                          state_d = S_DATA;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end
            end
            S_DATA: begin
                // word_cnt_q reaches N only in the cycle of the final strobe
                if (CW'(word_cnt_q) == CW'(n_q)) begin
                    state_d = S_DONE;
                end else if (frame_err_q) begin
                    state_d = S_ERR;
                end else if (byte_valid_q) begin
                    asm_d = (asm_q >> 8) | (DW'(shift_q) << (DW - 8));
                    if (byte_cnt_q == BCW'(BPW - 1)) begin
                        byte_cnt_d  = '0;
                        wmem_en_d   = 1'b1;
                        wmem_data_d = asm_d;
                        wmem_addr_d = word_cnt_q * ADDR_BIT'(BPW);
                        word_cnt_d  = word_cnt_q + ADDR_BIT'(1);
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        hold_d = (state_d == S_HDR) || (state_d == S_DATA);
        done_d = (state_d == S_DONE);
        if (state_d == S_ERR) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            n_q          <= '0;
            word_cnt_q   <= '0;
            wmem_en_q    <= 1'b0;
            wmem_addr_q  <= '0;
            wmem_data_q  <= '0;
            hold_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rx_s1_q      <= uart_rx_i;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
            rx_state_q   <= rx_state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            n_q          <= n_d;
            word_cnt_q   <= word_cnt_d;
            wmem_en_q    <= wmem_en_d;
            wmem_addr_q  <= wmem_addr_d;
            wmem_data_q  <= wmem_data_d;
            hold_q       <= hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign wmem_en_o   = wmem_en_q;
    assign wmem_addr_o = wmem_addr_q;
    assign wmem_data_o = wmem_data_q;
    assign core_hold_o = hold_q;
    assign load_done_o = done_q;
    assign err_o       = err_q;
    assign word_cnt_o  = word_cnt_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: table of load transactions plus glitch, full-depth and reset sequences.
module tb_uart_prog_loader;

    localparam int unsigned DW = 32, AW = 32, DEPTH = 16, BAUD = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          uart_rx = 1'b1;
    logic          load_req = 1'b0;
    logic          wmem_en, core_hold, load_done, err;
    logic [AW-1:0] wmem_addr, word_cnt;
    logic [DW-1:0] wmem_data;

    uart_prog_loader #(.DW(DW), .ADDR_BIT(AW), .DEPTH(DEPTH), .BAUD_DIV(BAUD)) dut (
        .clk(clk), .rst(rst), .uart_rx_i(uart_rx), .load_req_i(load_req),
        .wmem_en_o(wmem_en), .wmem_addr_o(wmem_addr), .wmem_data_o(wmem_data),
        .core_hold_o(core_hold), .load_done_o(load_done), .err_o(err), .word_cnt_o(word_cnt)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        string       name;
        int          nb;
        logic [95:0] bytes;   // byte 0 in the top bits
        int          bad;     // index of byte sent with stop bit 0, -1 for none
        int          exp_wr;
        logic [31:0] a0, d0, a1, d1;
        int          exp_cnt;
        int          exp_done;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          done_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        uart_rx = v;
        repeat (BAUD) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        uart_rx = 1'b1;
        repeat (2 * BAUD) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_req();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    // Write-port and done-pulse monitor
    initial begin
        logic prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (wmem_en) begin
                chk("no_back_to_back", 32'(prev_en), 32'd0);
                wr_addr.push_back(wmem_addr);
                wr_data.push_back(wmem_data);
            end
            if (load_done) begin
                done_cnt++;
                chk("hold_low_in_done", 32'(core_hold), 32'd0);
            end
            prev_en = wmem_en;
        end
    end

    initial begin
        vecs[0] = '{"normal",    12, 96'h02000000_13050000_93051000, -1, 2,
                    32'h0, 32'h00000513, 32'h4, 32'h00100593, 2, 1, 1'b0};
        vecs[1] = '{"zero_hdr",   4, 96'h00000000_00000000_00000000, -1, 0,
                    32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 1'b0};
        vecs[2] = '{"too_big",    4, 96'h11000000_00000000_00000000, -1, 0,
                    32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1};
        vecs[3] = '{"single",     8, 96'h01000000_AABBCCDD_00000000, -1, 1,
                    32'h0, 32'hDDCCBBAA, 32'h0, 32'h0, 1, 1, 1'b0};
        vecs[4] = '{"frame_d2",   6, 96'h02000000_13050000_00000000,  5, 0,
                    32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1};
        vecs[5] = '{"frame_hdr",  2, 96'h01000000_00000000_00000000,  1, 0,
                    32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1};
        vecs[6] = '{"frame_w2",  10, 96'h02000000_13050000_93050000,  9, 1,
                    32'h0, 32'h00000513, 32'h0, 32'h0, 1, 0, 1'b1};

        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.wmem_en", 32'(wmem_en), 32'd0);
        chk("rst.addr", wmem_addr, 32'd0);
        chk("rst.data", wmem_data, 32'd0);
        chk("rst.hold", 32'(core_hold), 32'd0);
        chk("rst.done", 32'(load_done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.cnt", word_cnt, 32'd0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            vec_t v;
            v = vecs[i];
            clear_mon();
            pulse_req();
            chk($sformatf("%s.hold_after_req", v.name), 32'(core_hold), 32'd1);
            chk($sformatf("%s.err_cleared", v.name), 32'(err), 32'd0);
            chk($sformatf("%s.cnt_cleared", v.name), word_cnt, 32'd0);
            for (int k = 0; k < v.nb; k++)
                send_byte(v.bytes[95-8*k -: 8], (k == v.bad) ? 1'b0 : 1'b1);
            repeat (30) @(posedge clk);
            #1;
            chk($sformatf("%s.writes", v.name), 32'(wr_addr.size()), 32'(v.exp_wr));
            if (v.exp_wr > 0 && wr_addr.size() > 0) begin
                chk($sformatf("%s.addr0", v.name), wr_addr[0], v.a0);
                chk($sformatf("%s.data0", v.name), wr_data[0], v.d0);
            end
            if (v.exp_wr > 1 && wr_addr.size() > 1) begin
                chk($sformatf("%s.addr1", v.name), wr_addr[1], v.a1);
                chk($sformatf("%s.data1", v.name), wr_data[1], v.d1);
            end
            chk($sformatf("%s.word_cnt", v.name), word_cnt, 32'(v.exp_cnt));
            chk($sformatf("%s.done_pulses", v.name), 32'(done_cnt), 32'(v.exp_done));
            chk($sformatf("%s.err", v.name), 32'(err), 32'(v.exp_err));
            chk($sformatf("%s.hold_end", v.name), 32'(core_hold), 32'd0);
        end

        // Short glitches in IDLE and HDR must not produce bytes
        clear_mon();
        uart_rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        pulse_req();
        uart_rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("glitch.hold_in_hdr", 32'(core_hold), 32'd1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        repeat (30) @(posedge clk);
        #1;
        chk("glitch.writes", 32'(wr_addr.size()), 32'd1);
        if (wr_data.size() > 0) chk("glitch.data", wr_data[0], 32'h44332211);
        chk("glitch.done", 32'(done_cnt), 32'd1);

        // Full-depth load: N = DEPTH is accepted
        clear_mon();
        pulse_req();
        send_byte(8'h10, 1'b1);
        for (int k = 0; k < 3; k++) send_byte(8'h00, 1'b1);
        for (int w = 0; w < 16; w++) begin
            send_byte(8'(w), 1'b1);
            send_byte(8'hA5, 1'b1);
            for (int k = 0; k < 2; k++) send_byte(8'h00, 1'b1);
        end
        repeat (30) @(posedge clk);
        #1;
        chk("depth.writes", 32'(wr_addr.size()), 32'd16);
        if (wr_addr.size() == 16) begin
            for (int w = 0; w < 16; w++) begin
                chk($sformatf("depth.addr%0d", w), wr_addr[w], 32'(4 * w));
                chk($sformatf("depth.data%0d", w), wr_data[w], 32'h0000A500 | 32'(w));
            end
        end
        chk("depth.cnt", word_cnt, 32'd16);
        chk("depth.done", 32'(done_cnt), 32'd1);
        chk("depth.err", 32'(err), 32'd0);

        // Reset in the middle of DATA aborts at once
        clear_mon();
        pulse_req();
        send_byte(8'h03, 1'b1);
        for (int k = 0; k < 3; k++) send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        chk("rstmid.writes_before", 32'(wr_addr.size()), 32'd1);
        chk("rstmid.hold_before", 32'(core_hold), 32'd1);
        rst = 1'b0;
        #1;
        chk("rstmid.wmem_en", 32'(wmem_en), 32'd0);
        chk("rstmid.addr", wmem_addr, 32'd0);
        chk("rstmid.data", wmem_data, 32'd0);
        chk("rstmid.hold", 32'(core_hold), 32'd0);
        chk("rstmid.done", 32'(load_done), 32'd0);
        chk("rstmid.err", 32'(err), 32'd0);
        chk("rstmid.cnt", word_cnt, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_mon();
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        send_byte(8'h99, 1'b1);
        send_byte(8'hAA, 1'b1);
        repeat (30) @(posedge clk);
        #1;
        chk("after_rst.writes", 32'(wr_addr.size()), 32'd0);
        chk("after_rst.hold", 32'(core_hold), 32'd0);
        chk("after_rst.cnt", word_cnt, 32'd0);
        chk("after_rst.done", 32'(done_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
